// File: rtl/fx3_sfifo_emu_if.sv
// ---------------------------------------------------------------------------
// fx3_sfifo_emu_if
//   GPIFII synchronous Slave FIFO bus as seen between the FPGA-side master
//   controller and the FX3 stand-in (fx3_sfifo_emu).
//
//   Signals
//     SLADDR   master -> FX3   endpoint address (0 = EP0 source, 1..3 sinks)
//     SLCSn    master -> FX3   chip select, active low
//     SLOEn    master -> FX3   output enable, active low
//     SLRDn    master -> FX3   read strobe, active low
//     SLWRn    master -> FX3   write strobe, active low
//     PKTENDn  master -> FX3   packet end, active low
//     DQ_w     master -> FX3   write data
//     DQ_r     FX3 -> master   read data
//     FLAGA    FX3 -> master   EP0 has data
//     FLAGB..D FX3 -> master   EP1..3 buffer accepting writes
//
//   Modports
//     master : FPGA controller side
//     slave  : FX3 emulator side
// ---------------------------------------------------------------------------
interface fx3_sfifo_emu_if #(
   parameter int GpifWidth = 32
) ();
   logic [1:0]           SLADDR;
   logic                 SLCSn;
   logic                 SLOEn;
   logic                 SLRDn;
   logic                 SLWRn;
   logic                 PKTENDn;
   logic [GpifWidth-1:0] DQ_w;
   logic [GpifWidth-1:0] DQ_r;
   logic                 FLAGA;
   logic                 FLAGB;
   logic                 FLAGC;
   logic                 FLAGD;

   modport master (
      output SLADDR, SLCSn, SLOEn, SLRDn, SLWRn, PKTENDn, DQ_w,
      input  DQ_r, FLAGA, FLAGB, FLAGC, FLAGD
   );

   modport slave (
      input  SLADDR, SLCSn, SLOEn, SLRDn, SLWRn, PKTENDn, DQ_w,
      output DQ_r, FLAGA, FLAGB, FLAGC, FLAGD
   );
endinterface

// File: rtl/fx3_sfifo_emu.sv
// ---------------------------------------------------------------------------
// fx3_sfifo_emu
//   Device-side emulator of the FX3 GPIFII synchronous Slave FIFO. It answers
//   the master strobes on the gpif bus, sources EP0 data from a small FIFO
//   filled by the host (src_*), and turns writes / packet ends on EP1..3 into
//   a single tagged output stream (snk_*). Each sink endpoint models one FX3
//   DMA buffer of BufWords words that must be released by the host before the
//   endpoint accepts data again.
//
//   Parameters
//     GpifWidth  DQ / stream data width
//     SrcAw      log2 depth of the EP0 source FIFO
//     BufWords   words per emulated DMA buffer on EP1..3 (>= 2)
//
//   Ports
//     clk_i       clock
//     rstn_i      synchronous reset, active low
//     gpif        GPIF slave-FIFO bus (slave modport)
//     src_dt_i    host push data into EP0
//     src_vld_i   host push valid
//     src_rdy_o   EP0 FIFO can take a push
//     snk_dt_o    sunk word (0 on a zero-length packet marker)
//     snk_ep_o    endpoint of the sunk word (1..3)
//     snk_vld_o   sunk beat valid, no backpressure
//     snk_last_o  beat closes the buffer (buffer full or PKTEND)
//     snk_zlp_o   beat is a zero-length packet marker
//     snk_rel_i   per-EP1..3 buffer release pulse from the host
//     err_o       sticky errors: [0] EP0 underflow, [1] sink overflow,
//                 [2] simultaneous RD/WR strobes
// ---------------------------------------------------------------------------
module fx3_sfifo_emu #(
   parameter int GpifWidth = 32,
   parameter int SrcAw     = 4,
   parameter int BufWords  = 16
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   fx3_sfifo_emu_if.slave       gpif,
   input  logic [GpifWidth-1:0] src_dt_i,
   input  logic                 src_vld_i,
   output logic                 src_rdy_o,
   output logic [GpifWidth-1:0] snk_dt_o,
   output logic [1:0]           snk_ep_o,
   output logic                 snk_vld_o,
   output logic                 snk_last_o,
   output logic                 snk_zlp_o,
   input  logic [2:0]           snk_rel_i,
   output logic [2:0]           err_o
);

   localparam int NumSink  = 3;
   localparam int SrcDepth = 1 << SrcAw;
   localparam int CntW     = (BufWords > 2) ? $clog2(BufWords) : 1;

   localparam logic [CntW-1:0]  LastIdx  = CntW'(BufWords - 1);
   localparam logic [CntW-1:0]  CntOne   = CntW'(1);
   localparam logic [SrcAw-1:0] PtrOne   = SrcAw'(1);
   localparam logic [SrcAw:0]   FillOne  = (SrcAw + 1)'(1);
   localparam logic [SrcAw:0]   RdyLimit = (SrcAw + 1)'(SrcDepth - 1);

   // ------------------------------------------------------------------------
   // Strobe decode. A cycle with RD and WR both asserted is flagged and
   // otherwise behaves like an idle cycle.
   // ------------------------------------------------------------------------
   logic cs;
   logic conflict;
   logic addr_src;
   logic rd;
   logic wr;
   logic pe;

   always_comb begin
      cs       = ~gpif.SLCSn;
      conflict = cs & ~gpif.SLRDn & ~gpif.SLWRn;
      addr_src = (gpif.SLADDR == 2'd0);
      rd       = cs & ~gpif.SLOEn & ~gpif.SLRDn & addr_src  & ~conflict;
      wr       = cs & ~gpif.SLWRn               & ~addr_src & ~conflict;
      pe       = cs & ~gpif.PKTENDn             & ~addr_src & ~conflict;
   end

   // ------------------------------------------------------------------------
   // EP0 source FIFO
   // ------------------------------------------------------------------------
   logic [GpifWidth-1:0] src_mem [SrcDepth];
   logic [GpifWidth-1:0] rd_word_q;
   logic [SrcAw-1:0]     wr_ptr_q, wr_ptr_d;
   logic [SrcAw-1:0]     rd_ptr_q, rd_ptr_d;
   logic [SrcAw:0]       fill_q, fill_d;
   logic                 src_rdy_q;
   logic                 flaga_q;
   logic                 rd_vld_q;
   logic                 rd_uf_q;
   logic [GpifWidth-1:0] dq_q;
   logic                 push;
   logic                 pop;
   logic                 underflow;

   always_comb begin
      push      = src_vld_i & src_rdy_q;
      pop       = rd & (fill_q != '0);
      underflow = rd & (fill_q == '0);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end
      case ({push, pop})
         2'b10:   fill_d = fill_q + FillOne;
         2'b01:   fill_d = fill_q - FillOne;
         default: fill_d = fill_q;
      endcase
   end

   // Storage with a registered read of the current head. The read happens
   // every cycle; the second stage only takes it when a pop was issued, so
   // the head word captured at the pop edge is the one that reaches DQ.
   // When the FIFO is full both pointers are equal; the read-before-write
   // behaviour returns the old head, which is the word being popped.
   always_ff @(posedge clk_i) begin
      if (push) begin
         src_mem[wr_ptr_q] <= src_dt_i;
      end
      rd_word_q <= src_mem[rd_ptr_q];
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fill_q    <= '0;
         src_rdy_q <= 1'b0;
         flaga_q   <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_uf_q   <= 1'b0;
         dq_q      <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         fill_q    <= fill_d;
         // Ready is one cycle stale, so it drops one word early: the push
         // accepted in the cycle it still reads high lands in the last slot.
         src_rdy_q <= (fill_q < RdyLimit);
         flaga_q   <= (fill_q != '0);
         rd_vld_q  <= rd;
         rd_uf_q   <= underflow;
         // DQ holds the last read result until the next read completes.
         if (rd_vld_q) begin
            dq_q <= rd_uf_q ? '0 : rd_word_q;
         end
      end
   end

   // ------------------------------------------------------------------------
   // EP1..3 sink buffers
   // ------------------------------------------------------------------------
   logic [NumSink-1:0] sel;
   logic [NumSink-1:0] at_last;
   logic [NumSink-1:0] held;
   logic [NumSink-1:0] ep_flag;
   logic               held_cur;
   logic               last_cur;
   logic               wr_fwd;
   logic               commit;
   logic               zlp;
   logic               drop;

   // Only the addressed endpoint matters for the beat; with SLADDR == 0 all
   // selects are low and wr/pe are already masked.
   always_comb begin
      held_cur = |(held & sel);
      last_cur = |(at_last & sel);
      wr_fwd   = wr & ~held_cur;
      commit   = wr_fwd & (pe | last_cur);
      zlp      = pe & ~wr & ~held_cur;
      drop     = (wr | pe) & held_cur;
   end

   for (genvar gi = 0; gi < NumSink; gi++) begin : g_sink
      logic [CntW-1:0] cnt_q, cnt_d;
      logic            held_q, held_d;
      logic            flag_q;

      assign sel[gi]     = (gpif.SLADDR == 2'(gi + 1));
      assign at_last[gi] = (cnt_q == LastIdx);
      assign held[gi]    = held_q;
      assign ep_flag[gi] = flag_q;

      // Commit takes priority over a release in the same cycle. A release
      // while the endpoint is not held simply leaves held at 0.
      always_comb begin
         cnt_d  = cnt_q;
         held_d = held_q;
         if (sel[gi] && (commit || zlp)) begin
            cnt_d  = '0;
            held_d = 1'b1;
         end else if (sel[gi] && wr_fwd) begin
            cnt_d = cnt_q + CntOne;
         end else if (snk_rel_i[gi]) begin
            held_d = 1'b0;
         end
      end

      always_ff @(posedge clk_i) begin
         if (!rstn_i) begin
            cnt_q  <= '0;
            held_q <= 1'b0;
            flag_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            held_q <= held_d;
            flag_q <= ~held_q;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Sink output beat and sticky errors
   // ------------------------------------------------------------------------
   logic [GpifWidth-1:0] snk_dt_q;
   logic [1:0]           snk_ep_q;
   logic                 snk_vld_q;
   logic                 snk_last_q;
   logic                 snk_zlp_q;
   logic [2:0]           err_q;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         snk_dt_q   <= '0;
         snk_ep_q   <= '0;
         snk_vld_q  <= 1'b0;
         snk_last_q <= 1'b0;
         snk_zlp_q  <= 1'b0;
         err_q      <= '0;
      end else begin
         snk_vld_q  <= wr_fwd | zlp;
         snk_dt_q   <= wr_fwd ? gpif.DQ_w : '0;
         snk_ep_q   <= (wr_fwd | zlp) ? gpif.SLADDR : 2'd0;
         snk_last_q <= commit | zlp;
         snk_zlp_q  <= zlp;
         err_q      <= err_q | {conflict, drop, underflow};
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign gpif.DQ_r  = dq_q;
   assign gpif.FLAGA = flaga_q;
   assign gpif.FLAGB = ep_flag[0];
   assign gpif.FLAGC = ep_flag[1];
   assign gpif.FLAGD = ep_flag[2];

   assign src_rdy_o  = src_rdy_q;
   assign snk_dt_o   = snk_dt_q;
   assign snk_ep_o   = snk_ep_q;
   assign snk_vld_o  = snk_vld_q;
   assign snk_last_o = snk_last_q;
   assign snk_zlp_o  = snk_zlp_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_fx3_sfifo_emu.sv
// ---------------------------------------------------------------------------
// tb_fx3_sfifo_emu
//   Directed bench for fx3_sfifo_emu. Reads and sink beats are checked
//   through scoreboard queues filled when the stimulus is driven; flags,
//   ready and error bits are checked directly at the cycle they must change.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fx3_sfifo_emu;
   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rstn;
   logic [W-1:0] src_dt;
   logic         src_vld;
   logic         src_rdy;
   logic [W-1:0] snk_dt;
   logic [1:0]   snk_ep;
   logic         snk_vld;
   logic         snk_last;
   logic         snk_zlp;
   logic [2:0]   snk_rel;
   logic [2:0]   err;

   fx3_sfifo_emu_if #(.GpifWidth(W)) gpif ();

   fx3_sfifo_emu #(
      .GpifWidth (W),
      .SrcAw     (4),
      .BufWords  (16)
   ) dut (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .gpif       (gpif),
      .src_dt_i   (src_dt),
      .src_vld_i  (src_vld),
      .src_rdy_o  (src_rdy),
      .snk_dt_o   (snk_dt),
      .snk_ep_o   (snk_ep),
      .snk_vld_o  (snk_vld),
      .snk_last_o (snk_last),
      .snk_zlp_o  (snk_zlp),
      .snk_rel_i  (snk_rel),
      .err_o      (err)
   );

   typedef struct packed {
      logic [W-1:0] dt;
      logic [1:0]   ep;
      logic         last;
      logic         zlp;
   } beat_t;

   int     n_checks = 0;
   int     n_errors = 0;
   logic [W-1:0] rd_q [$];
   beat_t  snk_q [$];
   logic [W-1:0] rd_exp_w;
   beat_t  beat_exp;
   beat_t  beat_obs;

   // Read results appear two edges after the read is sampled.
   bit rd_issue = 1'b0;
   bit rd_s1    = 1'b0;
   bit rd_s2    = 1'b0;
   always @(posedge clk) begin
      rd_s1 <= rd_issue;
      rd_s2 <= rd_s1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitors
   always @(negedge clk) begin
      if (rd_s2) begin
         n_checks++;
         assert (rd_q.size() != 0) else begin
            n_errors++;
            $error("FAIL dq_unexpected obs=%0h exp=none", gpif.DQ_r);
         end
         if (rd_q.size() != 0) begin
            rd_exp_w = rd_q.pop_front();
            $display("rd  dq=%08h", gpif.DQ_r);
            n_checks++;
            assert (gpif.DQ_r === rd_exp_w) else begin
               n_errors++;
               $error("FAIL dq_data obs=%0h exp=%0h", gpif.DQ_r, rd_exp_w);
            end
         end
      end
      if (snk_vld === 1'b1) begin
         beat_obs = {snk_dt, snk_ep, snk_last, snk_zlp};
         $display("snk ep=%0d dt=%08h last=%0b zlp=%0b", snk_ep, snk_dt, snk_last, snk_zlp);
         n_checks++;
         assert (snk_q.size() != 0) else begin
            n_errors++;
            $error("FAIL snk_unexpected obs=%0h exp=none", beat_obs);
         end
         if (snk_q.size() != 0) begin
            beat_exp = snk_q.pop_front();
            n_checks++;
            assert (beat_obs === beat_exp) else begin
               n_errors++;
               $error("FAIL snk_beat obs=%0h exp=%0h", beat_obs, beat_exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   // Stimulus helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      gpif.SLCSn   = 1'b1;
      gpif.SLOEn   = 1'b1;
      gpif.SLRDn   = 1'b1;
      gpif.SLWRn   = 1'b1;
      gpif.PKTENDn = 1'b1;
      gpif.SLADDR  = 2'd0;
      gpif.DQ_w    = '0;
      rd_issue     = 1'b0;
   endtask

   task automatic bus_rd(input logic [W-1:0] exp);
      gpif.SLCSn   = 1'b0;
      gpif.SLOEn   = 1'b0;
      gpif.SLRDn   = 1'b0;
      gpif.SLWRn   = 1'b1;
      gpif.PKTENDn = 1'b1;
      gpif.SLADDR  = 2'd0;
      rd_issue     = 1'b1;
      rd_q.push_back(exp);
      tick();
   endtask

   task automatic bus_wr(input logic [1:0] ep, input logic [W-1:0] d, input logic pe,
                         input logic exp_beat, input logic exp_last);
      beat_t b;
      gpif.SLCSn   = 1'b0;
      gpif.SLOEn   = 1'b1;
      gpif.SLRDn   = 1'b1;
      gpif.SLWRn   = 1'b0;
      gpif.PKTENDn = ~pe;
      gpif.SLADDR  = ep;
      gpif.DQ_w    = d;
      rd_issue     = 1'b0;
      b = {d, ep, exp_last, 1'b0};
      if (exp_beat) snk_q.push_back(b);
      tick();
   endtask

   task automatic bus_pe(input logic [1:0] ep);
      beat_t b;
      gpif.SLCSn   = 1'b0;
      gpif.SLOEn   = 1'b1;
      gpif.SLRDn   = 1'b1;
      gpif.SLWRn   = 1'b1;
      gpif.PKTENDn = 1'b0;
      gpif.SLADDR  = ep;
      gpif.DQ_w    = 32'hDEAD_BEEF;
      rd_issue     = 1'b0;
      b = {{W{1'b0}}, ep, 1'b1, 1'b1};
      snk_q.push_back(b);
      tick();
   endtask

   task automatic bus_conflict(input logic [1:0] addr);
      gpif.SLCSn   = 1'b0;
      gpif.SLOEn   = 1'b0;
      gpif.SLRDn   = 1'b0;
      gpif.SLWRn   = 1'b0;
      gpif.PKTENDn = 1'b0;
      gpif.SLADDR  = addr;
      gpif.DQ_w    = 32'h0BAD_0BAD;
      rd_issue     = 1'b0;
      tick();
   endtask

   task automatic src_push(input logic [W-1:0] d);
      src_dt  = d;
      src_vld = 1'b1;
      tick();
   endtask

   initial begin
      rstn    = 1'b0;
      src_dt  = '0;
      src_vld = 1'b0;
      snk_rel = 3'b000;
      bus_idle();
      repeat (3) tick();

      // Reset state
      chk("rst_dq",      64'(gpif.DQ_r),  64'd0);
      chk("rst_flaga",   64'(gpif.FLAGA), 64'd0);
      chk("rst_flagb",   64'(gpif.FLAGB), 64'd0);
      chk("rst_flagc",   64'(gpif.FLAGC), 64'd0);
      chk("rst_flagd",   64'(gpif.FLAGD), 64'd0);
      chk("rst_src_rdy", 64'(src_rdy),    64'd0);
      chk("rst_snk_vld", 64'(snk_vld),    64'd0);
      chk("rst_err",     64'(err),        64'd0);

      // First cycle after release
      rstn = 1'b1;
      tick();
      chk("rel_src_rdy", 64'(src_rdy),    64'd1);
      chk("rel_flaga",   64'(gpif.FLAGA), 64'd0);
      chk("rel_flagb",   64'(gpif.FLAGB), 64'd1);
      chk("rel_flagc",   64'(gpif.FLAGC), 64'd1);
      chk("rel_flagd",   64'(gpif.FLAGD), 64'd1);

      // EP0: push four words, read them back-to-back
      for (int i = 1; i <= 4; i++) src_push(W'(i));
      src_vld = 1'b0;
      tick();
      chk("ep0_flaga_set", 64'(gpif.FLAGA), 64'd1);
      for (int i = 1; i <= 4; i++) bus_rd(W'(i));
      bus_idle();
      chk("ep0_flaga_lag", 64'(gpif.FLAGA), 64'd1);
      tick();
      chk("ep0_flaga_clr", 64'(gpif.FLAGA), 64'd0);
      tick();
      tick();
      chk("ep0_rd_drained", 64'(rd_q.size()), 64'd0);
      chk("ep0_err",        64'(err),         64'd0);

      // EP2: fill one buffer
      for (int i = 0; i < 16; i++) bus_wr(2'd2, W'(32'h100 + i), 1'b0, 1'b1, (i == 15));
      bus_idle();
      tick();
      chk("ep2_flagc_held", 64'(gpif.FLAGC),  64'd0);
      chk("ep2_flagb",      64'(gpif.FLAGB),  64'd1);
      chk("ep2_flagd",      64'(gpif.FLAGD),  64'd1);
      chk("ep2_beats",      64'(snk_q.size()), 64'd0);

      // EP2 overflow while held
      bus_wr(2'd2, 32'h110, 1'b0, 1'b0, 1'b0);
      bus_idle();
      chk("ep2_ovf_err", 64'(err), 64'b010);
      tick();

      // Release EP2
      snk_rel = 3'b010;
      tick();
      snk_rel = 3'b000;
      chk("ep2_rel_lag",  64'(gpif.FLAGC), 64'd0);
      tick();
      chk("ep2_rel_flag", 64'(gpif.FLAGC), 64'd1);

      // EP1: short packet closed by PKTEND on the third word
      bus_wr(2'd1, 32'h200, 1'b0, 1'b1, 1'b0);
      bus_wr(2'd1, 32'h201, 1'b0, 1'b1, 1'b0);
      bus_wr(2'd1, 32'h202, 1'b1, 1'b1, 1'b1);
      bus_idle();
      tick();
      chk("ep1_flagb_held", 64'(gpif.FLAGB),   64'd0);
      chk("ep1_beats",      64'(snk_q.size()), 64'd0);
      snk_rel = 3'b001;
      tick();
      snk_rel = 3'b000;
      tick();
      chk("ep1_rel_flag", 64'(gpif.FLAGB), 64'd1);

      // EP1: zero-length packet
      bus_pe(2'd1);
      bus_idle();
      tick();
      chk("ep1_zlp_beats", 64'(snk_q.size()), 64'd0);
      chk("ep1_zlp_flagb", 64'(gpif.FLAGB),   64'd0);
      chk("ep1_zlp_err",   64'(err),          64'b010);

      // RD/WR conflict: no pop on EP0, no beat on EP3
      src_push(32'hAA);
      src_vld = 1'b0;
      tick();
      tick();
      bus_conflict(2'd0);
      bus_idle();
      chk("conf_err", 64'(err), 64'b110);
      bus_conflict(2'd3);
      bus_idle();
      tick();
      tick();
      chk("conf_no_pop", 64'(gpif.FLAGA), 64'd1);
      bus_rd(32'hAA);
      bus_idle();
      tick();
      tick();
      tick();

      // Underflow read returns zero
      bus_rd(32'h0);
      bus_idle();
      chk("uf_err", 64'(err), 64'b111);
      tick();
      tick();
      chk("uf_rd_drained", 64'(rd_q.size()), 64'd0);

      // Fill EP0 to 15 words
      for (int i = 0; i < 15; i++) src_push(W'(32'h300 + i));
      src_vld = 1'b0;
      chk("fill_rdy_15", 64'(src_rdy), 64'd1);
      tick();
      chk("fill_rdy_off", 64'(src_rdy),    64'd0);
      chk("fill_flaga",   64'(gpif.FLAGA), 64'd1);
      bus_rd(32'h300);
      bus_idle();
      tick();
      chk("fill_rdy_14", 64'(src_rdy), 64'd1);

      // Simultaneous push and pop keep the count at 14
      src_dt  = 32'h400;
      src_vld = 1'b1;
      bus_rd(32'h301);
      src_dt  = 32'h401;
      bus_rd(32'h302);
      src_vld = 1'b0;
      bus_idle();
      tick();
      chk("pp_rdy_same", 64'(src_rdy), 64'd1);
      src_push(32'h402);
      src_vld = 1'b0;
      tick();
      chk("pp_rdy_off", 64'(src_rdy), 64'd0);
      tick();
      chk("pp_rd_drained", 64'(rd_q.size()), 64'd0);

      // Reset in the middle of an EP3 burst with a push pending
      bus_wr(2'd3, 32'h500, 1'b0, 1'b1, 1'b0);
      bus_wr(2'd3, 32'h501, 1'b0, 1'b1, 1'b0);
      rstn         = 1'b0;
      src_dt       = 32'h600;
      src_vld      = 1'b1;
      bus_wr(2'd3, 32'h502, 1'b0, 1'b0, 1'b0);
      chk("mrst_snk_vld",  64'(snk_vld),    64'd0);
      chk("mrst_snk_dt",   64'(snk_dt),     64'd0);
      chk("mrst_snk_last", 64'(snk_last),   64'd0);
      chk("mrst_dq",       64'(gpif.DQ_r),  64'd0);
      chk("mrst_flaga",    64'(gpif.FLAGA), 64'd0);
      chk("mrst_flagd",    64'(gpif.FLAGD), 64'd0);
      chk("mrst_src_rdy",  64'(src_rdy),    64'd0);
      chk("mrst_err",      64'(err),        64'd0);
      chk("mrst_beats",    64'(snk_q.size()), 64'd0);
      bus_idle();
      src_vld = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      chk("post_src_rdy", 64'(src_rdy),    64'd1);
      chk("post_flagd",   64'(gpif.FLAGD), 64'd1);
      tick();
      chk("post_flaga",   64'(gpif.FLAGA), 64'd0);

      // EP3 word counter restarted from zero
      for (int i = 0; i < 16; i++) bus_wr(2'd3, W'(32'h700 + i), 1'b0, 1'b1, (i == 15));
      bus_idle();
      tick();
      chk("ep3_beats", 64'(snk_q.size()), 64'd0);
      chk("ep3_flagd", 64'(gpif.FLAGD),   64'd0);
      chk("ep3_err",   64'(err),          64'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
